argmax_classifier: RTL and testbench
====================================

Name: argmax_classifier

Overview:
- Downstream consumer of the dot-product stage's output vector: NUM_CLASSES signed fixed-point class scores, packed.
- Captures one score vector per handshake.
- Scans the scores sequentially, one comparison per cycle, and reports the winning class index and its score.
- Sits between the vector-matrix product and the result/display logic.

Parameters:
- NUM_CLASSES, 10, number of class scores per vector.
- SCORE_W, 26, width of each score; signed two's complement, 8 integer bits including sign and 18 fractional bits.
- IDX_W, 4, width of the class index; must satisfy 2**IDX_W >= NUM_CLASSES.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- GlobalReset  in  1  asynchronous, active-high reset.
- scores  in  NUM_CLASSES*SCORE_W  packed scores; class k occupies bits [k*SCORE_W +: SCORE_W].
- in_valid  in  1  scores valid.
- in_ready  out  1  block can accept a vector.
- class_idx  out  IDX_W  index of the maximum score.
- class_score  out  SCORE_W  the maximum score value.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts result.

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE.
  - Outputs: in_ready=1, out_valid=0, class_idx=0, class_score=0.
  - The internal score buffer, best index, best score and counter are all cleared.
  - A vector being scanned when reset asserts is discarded.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid && in_ready: register the whole scores vector, set best=score[0], best_idx=0, cnt=1, go to SCAN.
- SCAN:
  - in_ready=0.
  - Each cycle compare buf[cnt] against best as signed values.
  - If buf[cnt] > best (strictly), then best<=buf[cnt] and best_idx<=cnt.
  - cnt increments each cycle.
  - After cnt==NUM_CLASSES-1 is compared, go to DONE.
- DONE:
  - out_valid=1; class_idx and class_score are driven from registers and stay stable while out_valid=1 && !out_ready.
  - On out_ready: out_valid falls next cycle and the FSM returns to IDLE.
- Latency: accept edge to out_valid high is NUM_CLASSES-1 cycles of SCAN plus 1 cycle, i.e. 10 cycles for the defaults.
  - Throughput is one vector per NUM_CLASSES+1 cycles minimum; no overlap between vectors.
- Ties: the lowest index wins, because only a strictly greater score replaces the current best.
- Comparisons are always signed; the most negative value (sign bit 1, all other bits 0) is handled correctly.
- NUM_CLASSES=1: SCAN is skipped and the FSM goes IDLE -> DONE directly; result is index 0.
- in_valid asserted while busy is ignored (in_ready=0); the upstream stage holds the vector.
- Outputs class_idx and class_score keep their last value after the handshake until the next result overwrites them.

Optional Feature:
- Macro: ARGMAX_MARGIN_EN.
- When defined, two extra outputs are added:
  - runner_idx (IDX_W): index of the second-highest score.
  - margin (SCORE_W+1, unsigned): class_score minus runner-up score; always >= 0.
- Runner-up tracking during SCAN:
  - A new maximum demotes the old best to runner-up.
  - A score that is not a new maximum but is strictly greater than the runner-up replaces the runner-up.
  - Initial runner-up is the most negative value with runner_idx=0.
  - With NUM_CLASSES=1, margin=0 and runner_idx=0.
- Both extra outputs are reset to 0 and are valid under the same out_valid.
- When not defined: these ports and their registers do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package nn_pkg:
  - NUM_CLASSES, SCORE_W, FRAC_W=18, IDX_W.
  - typedef score_t (signed SCORE_W).
  - typedef class_idx_t.
  - FSM state enum argmax_state_t.
- One sub-module, score_compare: combinational signed greater-than plus select, reused for both the best and runner-up updates.

Test Plan:
- Reset mid-SCAN: assert GlobalReset at cycle 3 of a scan -> out_valid=0 immediately, in_ready=1, class_idx=0; the next vector is processed normally.
- Distinct scores: score[k]=k*0x40000 (k.0), k=0..9 -> after 10 cycles out_valid=1, class_idx=9, class_score=0x240000.
- All negative: score[k]=-(k+1).0 -> class_idx=0, class_score=0x3FC0000 (-1.0). Tie: score[3]=score[7]=5.0, others 0 -> class_idx=3.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 and a new vector -> outputs stable, in_ready=0; after out_ready=1, the second vector is accepted next cycle and its result is correct.
- ARGMAX_MARGIN_EN: scores 2.0 at index 4, 1.5 at index 8, rest 0 -> runner_idx=8, margin=0x20000 (0.5).

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and constants for the classifier back end.
package nn_pkg;

    localparam int unsigned NUM_CLASSES = 10;
    localparam int unsigned SCORE_W     = 26;
    localparam int unsigned FRAC_W      = 18;
    localparam int unsigned IDX_W       = 4;

    typedef logic signed [SCORE_W-1:0] score_t;
    typedef logic [IDX_W-1:0]          class_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } argmax_state_t;

    // Sign bit set, all other bits clear: the smallest representable score.
    localparam score_t SCORE_MOST_NEG = score_t'({1'b1, {(SCORE_W-1){1'b0}}});

endpackage

// File: rtl/score_compare.sv
// Signed strict greater-than between a candidate and an incumbent score,
// returning whichever one should be kept along with its class index.
module score_compare
    import nn_pkg::*;
(
    input  logic [SCORE_W-1:0] cand_i,
    input  logic [IDX_W-1:0]   cand_idx_i,
    input  logic [SCORE_W-1:0] inc_i,
    input  logic [IDX_W-1:0]   inc_idx_i,
    output logic               gt_c_o,
    output logic [SCORE_W-1:0] sel_c_o,
    output logic [IDX_W-1:0]   sel_idx_c_o
);

    // Equal scores keep the incumbent, so the earlier index wins ties.
    always_comb begin
        gt_c_o      = ($signed(cand_i) > $signed(inc_i));
        sel_c_o     = gt_c_o ? cand_i     : inc_i;
        sel_idx_c_o = gt_c_o ? cand_idx_i : inc_idx_i;
    end

endmodule

// File: rtl/argmax_classifier.sv
// Argmax over a captured vector of signed class scores, one comparison per
// cycle. Define ARGMAX_MARGIN_EN to also report the runner-up index and the
// winning margin.
module argmax_classifier
    import nn_pkg::*;
(
    input  logic                           clk,
    input  logic                           GlobalReset,
    input  logic [NUM_CLASSES*SCORE_W-1:0] scores,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [IDX_W-1:0]               class_idx,
    output logic [SCORE_W-1:0]             class_score,
    output logic                           out_valid,
`ifdef ARGMAX_MARGIN_EN
    output logic [IDX_W-1:0]               runner_idx,
    output logic [SCORE_W:0]               margin,
`endif
    input  logic                           out_ready
);

    localparam class_idx_t LAST_IDX = class_idx_t'(NUM_CLASSES - 1);

    argmax_state_t state_q, state_d;
    score_t        buf_q [NUM_CLASSES];
    score_t        buf_d [NUM_CLASSES];
    score_t        best_q, best_d;
    class_idx_t    best_idx_q, best_idx_d;
    class_idx_t    cnt_q, cnt_d;
    class_idx_t    class_idx_q, class_idx_d;
    score_t        class_score_q, class_score_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;

    score_t        cand;
    logic          best_gt;
    score_t        best_sel;
    class_idx_t    best_sel_idx;

`ifdef ARGMAX_MARGIN_EN
    score_t             runner_q, runner_d;
    class_idx_t         runner_idx_q, runner_idx_d;
    class_idx_t         runner_out_q, runner_out_d;
    logic [SCORE_W:0]   margin_q, margin_d;
    logic               run_gt;
    score_t             run_sel;
    class_idx_t         run_sel_idx;
`endif

    assign cand = buf_q[cnt_q];

    score_compare u_best_cmp (
        .cand_i      (cand),
        .cand_idx_i  (cnt_q),
        .inc_i       (best_q),
        .inc_idx_i   (best_idx_q),
        .gt_c_o      (best_gt),
        .sel_c_o     (best_sel),
        .sel_idx_c_o (best_sel_idx)
    );

`ifdef ARGMAX_MARGIN_EN
    score_compare u_run_cmp (
        .cand_i      (cand),
        .cand_idx_i  (cnt_q),
        .inc_i       (runner_q),
        .inc_idx_i   (runner_idx_q),
        .gt_c_o      (run_gt),
        .sel_c_o     (run_sel),
        .sel_idx_c_o (run_sel_idx)
    );
`endif

    // Next-state and datapath updates for the capture / scan / hold sequence.
    always_comb begin
        state_d       = state_q;
        buf_d         = buf_q;
        best_d        = best_q;
        best_idx_d    = best_idx_q;
        cnt_d         = cnt_q;
        class_idx_d   = class_idx_q;
        class_score_d = class_score_q;
        in_ready_d    = in_ready_q;
        out_valid_d   = out_valid_q;
`ifdef ARGMAX_MARGIN_EN
        runner_d      = runner_q;
        runner_idx_d  = runner_idx_q;
        runner_out_d  = runner_out_q;
        margin_d      = margin_q;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
                        buf_d[k] = score_t'(scores[k*SCORE_W +: SCORE_W]);
                    end
                    best_d     = score_t'(scores[SCORE_W-1:0]);
                    best_idx_d = '0;
                    cnt_d      = class_idx_t'(1);
                    in_ready_d = 1'b0;
`ifdef ARGMAX_MARGIN_EN
                    runner_d     = SCORE_MOST_NEG;
                    runner_idx_d = '0;
`endif
                    if (NUM_CLASSES == 1) begin
                        // Single class: nothing to scan, publish index 0 directly.
                        state_d       = DONE;
                        out_valid_d   = 1'b1;
                        class_idx_d   = '0;
                        class_score_d = score_t'(scores[SCORE_W-1:0]);
`ifdef ARGMAX_MARGIN_EN
                        runner_out_d  = '0;
                        margin_d      = '0;
`endif
                    end else begin
                        state_d = SCAN;
                    end
                end
            end

            SCAN: begin
                best_d     = best_sel;
                best_idx_d = best_sel_idx;
                cnt_d      = cnt_q + class_idx_t'(1);
`ifdef ARGMAX_MARGIN_EN
                // A new maximum pushes the old best down to runner-up.
                if (best_gt) begin
                    runner_d     = best_q;
                    runner_idx_d = best_idx_q;
                end else if (run_gt) begin
                    runner_d     = run_sel;
                    runner_idx_d = run_sel_idx;
                end
`else
                if (best_gt) begin
                    best_d = cand;
                end
`endif
                if (cnt_q == LAST_IDX) begin
                    state_d       = DONE;
                    out_valid_d   = 1'b1;
                    class_idx_d   = best_idx_d;
                    class_score_d = best_d;
`ifdef ARGMAX_MARGIN_EN
                    runner_out_d  = runner_idx_d;
                    margin_d      = (SCORE_W+1)'(best_d) - (SCORE_W+1)'(runner_d);
`endif
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end

            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    // State and datapath registers; reset drops any vector in flight.
    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            state_q       <= IDLE;
            for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
                buf_q[k] <= '0;
            end
            best_q        <= '0;
            best_idx_q    <= '0;
            cnt_q         <= '0;
            class_idx_q   <= '0;
            class_score_q <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
            runner_q      <= '0;
            runner_idx_q  <= '0;
            runner_out_q  <= '0;
            margin_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            buf_q         <= buf_d;
            best_q        <= best_d;
            best_idx_q    <= best_idx_d;
            cnt_q         <= cnt_d;
            class_idx_q   <= class_idx_d;
            class_score_q <= class_score_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
`ifdef ARGMAX_MARGIN_EN
            runner_q      <= runner_d;
            runner_idx_q  <= runner_idx_d;
            runner_out_q  <= runner_out_d;
            margin_q      <= margin_d;
`endif
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign class_idx   = class_idx_q;
    assign class_score = class_score_q;
`ifdef ARGMAX_MARGIN_EN
    assign runner_idx  = runner_out_q;
    assign margin      = margin_q;
`endif

endmodule

// File: tb/tb_argmax_classifier.sv
// Bench for argmax_classifier: directed cases plus random vectors checked
// against a whole-vector argmax model.
module tb_argmax_classifier;

    localparam int NC = 10;
    localparam int SW = 26;
    localparam int IW = 4;

    typedef logic [SW-1:0] vec_t [NC];

    logic              clk = 1'b0;
    logic              GlobalReset;
    logic [NC*SW-1:0]  scores;
    logic              in_valid;
    logic              in_ready;
    logic [IW-1:0]     class_idx;
    logic [SW-1:0]     class_score;
    logic              out_valid;
    logic              out_ready;
`ifdef ARGMAX_MARGIN_EN
    logic [IW-1:0]     runner_idx;
    logic [SW:0]       margin;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    argmax_classifier dut (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .scores      (scores),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .class_idx   (class_idx),
        .class_score (class_score),
        .out_valid   (out_valid),
`ifdef ARGMAX_MARGIN_EN
        .runner_idx  (runner_idx),
        .margin      (margin),
`endif
        .out_ready   (out_ready)
    );

    function automatic logic [NC*SW-1:0] pack(input vec_t v);
        logic [NC*SW-1:0] p;
        for (int k = 0; k < NC; k++) p[k*SW +: SW] = v[k];
        return p;
    endfunction

    // Whole number to Q8.18.
    function automatic logic [SW-1:0] fx(input int whole);
        return SW'(whole * 262144);
    endfunction

    // Reference: first index of the maximum; runner-up is the best of the rest.
    task automatic model(input vec_t v, output logic [IW-1:0] bi, output logic [SW-1:0] bv,
                         output logic [IW-1:0] ri, output logic [SW:0] mg);
        int b = 0;
        int r = -1;
        logic [SW-1:0] most_neg;
        most_neg = {1'b1, {(SW-1){1'b0}}};
        for (int k = 1; k < NC; k++)
            if ($signed(v[k]) > $signed(v[b])) b = k;
        for (int k = 0; k < NC; k++)
            if (k != b && (r < 0 || $signed(v[k]) > $signed(v[r]))) r = k;
        bi = IW'(b);
        bv = v[b];
        ri = (v[r] == most_neg) ? '0 : IW'(r);
        mg = {v[b][SW-1], v[b]} - {v[r][SW-1], v[r]};
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a vector and return just after the accepting edge.
    task automatic present(input vec_t v);
        int g = 0;
        @(negedge clk);
        scores   = pack(v);
        in_valid = 1'b1;
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("accept_wait", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Count rising edges from the accepting edge until out_valid is seen.
    task automatic wait_result(output int lat);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input vec_t v, input int lat);
        logic [IW-1:0] bi, ri;
        logic [SW-1:0] bv;
        logic [SW:0]   mg;
        model(v, bi, bv, ri, mg);
        check({tag, "_lat"},   32'(lat), 32'd10);
        check({tag, "_idx"},   32'(class_idx), 32'(bi));
        check({tag, "_score"}, 32'(class_score), 32'(bv));
`ifdef ARGMAX_MARGIN_EN
        check({tag, "_runner"}, 32'(runner_idx), 32'(ri));
        check({tag, "_margin"}, 32'(margin), 32'(mg));
`else
        if (ri > bi && mg == '1) $display("note: %s", tag);
`endif
    endtask

    task automatic release_result(input string tag);
        @(negedge clk);
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_ovfall"}, 32'(out_valid), 32'd0);
        check({tag, "_idle"},   32'(in_ready), 32'd1);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int lat;
        present(v);
        wait_result(lat);
        check_result(tag, v, lat);
        release_result(tag);
    endtask

    initial begin
        vec_t v, vb;
        int   lat;
        logic [IW-1:0] hold_idx;
        logic [SW-1:0] hold_score;

        GlobalReset = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        scores      = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready",  32'(in_ready),    32'd1);
        check("rst_out_valid", 32'(out_valid),   32'd0);
        check("rst_idx",       32'(class_idx),   32'd0);
        check("rst_score",     32'(class_score), 32'd0);
        GlobalReset = 1'b0;

        // Ascending whole numbers: last class wins.
        for (int k = 0; k < NC; k++) v[k] = fx(k);
        run_vec("ascend", v);
        check("ascend_hold_idx",   32'(class_idx),   32'd9);
        check("ascend_hold_score", 32'(class_score), 32'h0240000);

        // All negative: -1.0 at index 0 is the maximum.
        for (int k = 0; k < NC; k++) v[k] = fx(-(k + 1));
        run_vec("neg", v);
        check("neg_hold_idx",   32'(class_idx),   32'd0);
        check("neg_hold_score", 32'(class_score), 32'h3FC0000);

        // Tie between 3 and 7: lower index wins.
        for (int k = 0; k < NC; k++) v[k] = '0;
        v[3] = fx(5);
        v[7] = fx(5);
        run_vec("tie", v);
        check("tie_hold_idx", 32'(class_idx), 32'd3);

        // Reset in the middle of a scan.
        for (int k = 0; k < NC; k++) v[k] = fx(NC - k);
        present(v);
        repeat (2) @(posedge clk);
        @(negedge clk);
        GlobalReset = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid),   32'd0);
        check("midrst_in_ready",  32'(in_ready),    32'd1);
        check("midrst_idx",       32'(class_idx),   32'd0);
        check("midrst_score",     32'(class_score), 32'd0);
        @(negedge clk);
        GlobalReset = 1'b0;
        for (int k = 0; k < NC; k++) v[k] = fx(k % 4);
        v[6] = fx(11);
        run_vec("postrst", v);

        // Backpressure with a second vector waiting upstream.
        for (int k = 0; k < NC; k++) v[k] = SW'($urandom);
        for (int k = 0; k < NC; k++) vb[k] = SW'($urandom);
        present(v);
        wait_result(lat);
        check_result("bp_a", v, lat);
        hold_idx   = class_idx;
        hold_score = class_score;
        scores     = pack(vb);
        in_valid   = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(out_valid),   32'd1);
            check("bp_hold_ready", 32'(in_ready),    32'd0);
            check("bp_hold_idx",   32'(class_idx),   32'(hold_idx));
            check("bp_hold_score", 32'(class_score), 32'(hold_score));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_ovfall", 32'(out_valid), 32'd0);
        check("bp_ready",  32'(in_ready),  32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_result(lat);
        check_result("bp_b", vb, lat);
        release_result("bp_b");

        // Random vectors; odd iterations use a small value set to force ties
        // and include the most negative score.
        for (int n = 0; n < 16; n++) begin
            for (int k = 0; k < NC; k++) begin
                if (n % 2 == 1) begin
                    case ($urandom_range(0, 3))
                        0: v[k] = {1'b1, {(SW-1){1'b0}}};
                        1: v[k] = fx(-1);
                        2: v[k] = '0;
                        default: v[k] = fx(5);
                    endcase
                end else begin
                    v[k] = SW'($urandom);
                end
            end
            run_vec("rand", v);
        end

`ifdef ARGMAX_MARGIN_EN
        for (int k = 0; k < NC; k++) v[k] = '0;
        v[4] = fx(2);
        v[8] = 26'h0060000;
        run_vec("margin", v);
        check("margin_runner", 32'(runner_idx), 32'd8);
        check("margin_value",  32'(margin),     32'h0020000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
